// File: rtl/button_conditioner.sv
// Push-button front end: two-flop synchroniser, counter-based debounce FSM,
// registered clean level plus one-cycle press, release and long-hold strobes.
module button_conditioner #(
    parameter int DEBOUNCE_CYCLES = 120000,
    parameter int HOLD_CYCLES     = 12000000,
    parameter bit ACTIVE_LOW      = 1'b1,
    parameter int CNT_W           = 24
) (
    input  logic clk,
    input  logic rst,
    input  logic btn_in,
    output logic btn_level,
    output logic press_pulse,
    output logic release_pulse,
    output logic hold_pulse
);

    typedef enum logic [1:0] {
        RELEASED     = 2'd0,
        PRESS_WAIT   = 2'd1,
        PRESSED      = 2'd2,
        RELEASE_WAIT = 2'd3
    } state_t;

    localparam logic             IDLE_LVL  = ACTIVE_LOW ? 1'b1 : 1'b0;
    localparam logic [CNT_W-1:0] DB_LAST   = CNT_W'(DEBOUNCE_CYCLES - 1);
    localparam logic [CNT_W-1:0] HOLD_LAST = CNT_W'(HOLD_CYCLES - 1);
    localparam logic [CNT_W-1:0] CNT_ONE   = CNT_W'(1);

    logic             r_sync1;
    logic             r_sync2;
    state_t           r_state;
    logic [CNT_W-1:0] r_dbCnt;
    logic [CNT_W-1:0] r_holdCnt;
    logic             r_holdDone;
    logic             r_level;
    logic             r_press;
    logic             r_release;
    logic             r_hold;

    logic             w_pressed;
    state_t           w_nextState;
    logic [CNT_W-1:0] w_nextDbCnt;
    logic [CNT_W-1:0] w_nextHoldCnt;
    logic             w_nextHoldDone;
    logic             w_nextLevel;
    logic             w_nextPress;
    logic             w_nextRelease;
    logic             w_nextHold;

    assign w_pressed = ACTIVE_LOW ? ~r_sync2 : r_sync2;

    // Synchroniser flops reset to the released pin level so no false press follows reset.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_sync1    <= IDLE_LVL;
            r_sync2    <= IDLE_LVL;
            r_state    <= RELEASED;
            r_dbCnt    <= '0;
            r_holdCnt  <= '0;
            r_holdDone <= 1'b0;
            r_level    <= 1'b0;
            r_press    <= 1'b0;
            r_release  <= 1'b0;
            r_hold     <= 1'b0;
        end else begin
            r_sync1    <= btn_in;
            r_sync2    <= r_sync1;
            r_state    <= w_nextState;
            r_dbCnt    <= w_nextDbCnt;
            r_holdCnt  <= w_nextHoldCnt;
            r_holdDone <= w_nextHoldDone;
            r_level    <= w_nextLevel;
            r_press    <= w_nextPress;
            r_release  <= w_nextRelease;
            r_hold     <= w_nextHold;
        end
    end

    always_comb begin
        w_nextState    = r_state;
        w_nextDbCnt    = r_dbCnt;
        w_nextHoldCnt  = r_holdCnt;
        w_nextHoldDone = r_holdDone;
        w_nextLevel    = r_level;
        w_nextPress    = 1'b0;
        w_nextRelease  = 1'b0;
        w_nextHold     = 1'b0;
        case (r_state)
            RELEASED: begin
                if (w_pressed) begin
                    w_nextState = PRESS_WAIT;
                    w_nextDbCnt = '0;
                end
            end
            PRESS_WAIT: begin
                if (!w_pressed) begin
                    w_nextState = RELEASED;
                end else if (r_dbCnt == DB_LAST) begin
                    w_nextState    = PRESSED;
                    w_nextLevel    = 1'b1;
                    w_nextPress    = 1'b1;
                    w_nextHoldCnt  = '0;
                    w_nextHoldDone = 1'b0;
                end else begin
                    w_nextDbCnt = r_dbCnt + CNT_ONE;
                end
            end
            // A falling input wins over hold counting; the hold count stays frozen until we return.
            PRESSED: begin
                if (!w_pressed) begin
                    w_nextState = RELEASE_WAIT;
                    w_nextDbCnt = '0;
                end else if (!r_holdDone) begin
                    if (r_holdCnt == HOLD_LAST) begin
                        w_nextHold     = 1'b1;
                        w_nextHoldDone = 1'b1;
                    end else begin
                        w_nextHoldCnt = r_holdCnt + CNT_ONE;
                    end
                end
            end
            RELEASE_WAIT: begin
                if (w_pressed) begin
                    w_nextState = PRESSED;
                end else if (r_dbCnt == DB_LAST) begin
                    w_nextState   = RELEASED;
                    w_nextLevel   = 1'b0;
                    w_nextRelease = 1'b1;
                end else begin
                    w_nextDbCnt = r_dbCnt + CNT_ONE;
                end
            end
            default: begin
                w_nextState = RELEASED;
                w_nextDbCnt = '0;
                w_nextLevel = 1'b0;
            end
        endcase
    end

    assign btn_level     = r_level;
    assign press_pulse   = r_press;
    assign release_pulse = r_release;
    assign hold_pulse    = r_hold;

endmodule

// File: tb/tb_button_conditioner.sv
// Directed bench for button_conditioner: table of per-cycle vectors on an active-low
// and an active-high instance, then hand-timed bounce, glitch, hold and reset sequences.
module tb_button_conditioner;

    typedef struct {
        logic       rst;
        logic       btnLow;
        logic       btnHigh;
        logic [3:0] expLow;
        logic [3:0] expHigh;
    } vec_t;

    logic clk     = 1'b0;
    logic rst     = 1'b1;
    logic btnLow  = 1'b1;
    logic btnHigh = 1'b0;

    logic levelLow, pressLow, releaseLow, holdLow;
    logic levelHigh, pressHigh, releaseHigh, holdHigh;
    logic [3:0] obsLow;
    logic [3:0] obsHigh;

    int   testsRun    = 0;
    int   testsFailed = 0;
    vec_t vecs[$];

    assign obsLow  = {levelLow, pressLow, releaseLow, holdLow};
    assign obsHigh = {levelHigh, pressHigh, releaseHigh, holdHigh};

    always #5 clk = ~clk;

    button_conditioner #(
        .DEBOUNCE_CYCLES(4), .HOLD_CYCLES(8), .ACTIVE_LOW(1'b1), .CNT_W(8)
    ) dutLow (
        .clk(clk), .rst(rst), .btn_in(btnLow),
        .btn_level(levelLow), .press_pulse(pressLow),
        .release_pulse(releaseLow), .hold_pulse(holdLow)
    );

    button_conditioner #(
        .DEBOUNCE_CYCLES(4), .HOLD_CYCLES(8), .ACTIVE_LOW(1'b0), .CNT_W(8)
    ) dutHigh (
        .clk(clk), .rst(rst), .btn_in(btnHigh),
        .btn_level(levelHigh), .press_pulse(pressHigh),
        .release_pulse(releaseHigh), .hold_pulse(holdHigh)
    );

    function automatic void addVec(input logic r, input logic bl, input logic bh,
                                   input logic [3:0] el, input logic [3:0] eh);
        vec_t v;
        v.rst = r; v.btnLow = bl; v.btnHigh = bh; v.expLow = el; v.expHigh = eh;
        vecs.push_back(v);
    endfunction

    task automatic applyStimulus(input logic r, input logic bl, input logic bh);
        rst     = r;
        btnLow  = bl;
        btnHigh = bh;
        @(posedge clk);
        #1;
    endtask

    task automatic checkOutput(input string name, input int cycle,
                               input logic [3:0] got, input logic [3:0] exp);
        testsRun++;
        if (got !== exp) begin
            testsFailed++;
            $display("[TB] FAIL %s cycle %0d: got {level,press,release,hold}=%b, expected %b",
                     name, cycle, got, exp);
        end
    endtask

    initial begin
        logic [3:0] exp;

        // Reset, then a clean press and release on both polarities (edge 0 = index 2).
        addVec(1'b1, 1'b1, 1'b0, 4'b0000, 4'b0000);
        addVec(1'b1, 1'b1, 1'b0, 4'b0000, 4'b0000);
        for (int i = 0; i < 6; i++) addVec(1'b0, 1'b0, 1'b1, 4'b0000, 4'b0000);
        addVec(1'b0, 1'b0, 1'b1, 4'b1100, 4'b1100);
        for (int i = 0; i < 3; i++) addVec(1'b0, 1'b0, 1'b1, 4'b1000, 4'b1000);
        for (int i = 0; i < 6; i++) addVec(1'b0, 1'b1, 1'b0, 4'b1000, 4'b1000);
        addVec(1'b0, 1'b1, 1'b0, 4'b0010, 4'b0010);
        addVec(1'b0, 1'b1, 1'b0, 4'b0000, 4'b0000);
        addVec(1'b0, 1'b1, 1'b0, 4'b0000, 4'b0000);

        for (int i = 0; i < vecs.size(); i++) begin
            applyStimulus(vecs[i].rst, vecs[i].btnLow, vecs[i].btnHigh);
            checkOutput("tableLow", i, obsLow, vecs[i].expLow);
            checkOutput("tableHigh", i, obsHigh, vecs[i].expHigh);
        end

        // Bounce: 3 cycles low, 2 high, five times, then settle high.
        for (int rep = 0; rep < 5; rep++) begin
            for (int k = 0; k < 5; k++) begin
                applyStimulus(1'b0, (k < 3) ? 1'b0 : 1'b1, 1'b0);
                checkOutput("bounce", rep * 5 + k, obsLow, 4'b0000);
            end
        end
        for (int k = 0; k < 4; k++) begin
            applyStimulus(1'b0, 1'b1, 1'b0);
            checkOutput("bounceSettle", k, obsLow, 4'b0000);
        end

        // Glitch during release: low 0-7, high 8-9, low 10-11, high from 12.
        for (int k = 0; k < 22; k++) begin
            if (k == 6)                exp = 4'b1100;
            else if (k > 6 && k < 18)  exp = 4'b1000;
            else if (k == 18)          exp = 4'b0010;
            else                       exp = 4'b0000;
            applyStimulus(1'b0, (k < 8 || k == 10 || k == 11) ? 1'b0 : 1'b1, 1'b0);
            checkOutput("glitchRelease", k, obsLow, exp);
        end

        // Long hold: press at 6, hold at 14, release pin at 40, release pulse at 46.
        for (int k = 0; k < 50; k++) begin
            if (k == 6)                exp = 4'b1100;
            else if (k == 14)          exp = 4'b1001;
            else if (k > 6 && k < 46)  exp = 4'b1000;
            else if (k == 46)          exp = 4'b0010;
            else                       exp = 4'b0000;
            applyStimulus(1'b0, (k < 40) ? 1'b0 : 1'b1, 1'b0);
            checkOutput("hold", k, obsLow, exp);
        end

        // Reset while PRESSED with the pin held: fresh press 6 edges after deassert.
        for (int k = 0; k < 26; k++) begin
            if (k == 6 || k == 16)                        exp = 4'b1100;
            else if ((k > 6 && k < 9) || (k > 16 && k < 24)) exp = 4'b1000;
            else if (k == 24)                             exp = 4'b0010;
            else                                          exp = 4'b0000;
            applyStimulus((k == 9) ? 1'b1 : 1'b0, (k < 18) ? 1'b0 : 1'b1, 1'b0);
            checkOutput("resetMidPress", k, obsLow, exp);
        end

        $display("[TB] %0d tests run, %0d failed", testsRun, testsFailed);
        $finish;
    end

endmodule
